// File: rtl/bist_pkg.sv
// Shared encodings for the BIST pattern generator: pattern modes,
// controller states and a mode validity helper.
package bist_pkg;

  localparam int BIST_MODE_W = 3;

  // Pattern modes selectable at start; encodings 5..7 are reserved.
  typedef enum logic [BIST_MODE_W-1:0] {
    BIST_MODE_LFSR  = 3'd0,
    BIST_MODE_CNT   = 3'd1,
    BIST_MODE_WALK  = 3'd2,
    BIST_MODE_CHK   = 3'd3,
    BIST_MODE_SHIFT = 3'd4
  } bist_mode_e;

  // Controller states: IDLE waits for start, RUN issues patterns.
  typedef enum logic {
    BIST_ST_IDLE = 1'b0,
    BIST_ST_RUN  = 1'b1
  } bist_state_e;

  // True for the five implemented modes, false for reserved codes.
  function automatic logic bist_mode_valid(input logic [BIST_MODE_W-1:0] mode);
    return (mode <= BIST_MODE_SHIFT);
  endfunction

endpackage

// File: rtl/bist_pattern_next.sv
// Combinational pattern function: the first pattern of a run (from the
// seed) and the successor of the current pattern, for the selected mode.
module bist_pattern_next
  import bist_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'hB8
) (
  input  logic [BIST_MODE_W-1:0] i_mode,
  input  logic [WIDTH-1:0]       i_data,
  input  logic [WIDTH-1:0]       i_seed,
  input  logic                   i_serial_in,
  output logic [WIDTH-1:0]       o_next,
  output logic [WIDTH-1:0]       o_first
);

  // Checkerboard base pattern: ones on even bit positions (0x55 at 8 bits).
  logic [WIDTH-1:0] w_chk;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chk
    assign w_chk[gi] = ((gi % 2) == 0);
  end

  // Galois LFSR step: shift right, fold the taps in when the LSB drops out.
  logic [WIDTH-1:0] w_lfsr_next;
  assign w_lfsr_next = (i_data >> 1) ^ (i_data[0] ? POLY : {WIDTH{1'b0}});

  // Successor pattern; reserved modes never reach RUN, so they just hold.
  always_comb begin
    o_next = i_data;
    case (bist_mode_e'(i_mode))
      BIST_MODE_LFSR:  o_next = w_lfsr_next;
      BIST_MODE_CNT:   o_next = i_data + WIDTH'(1);
      BIST_MODE_WALK:  o_next = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
      BIST_MODE_CHK:   o_next = ~i_data;
      BIST_MODE_SHIFT: o_next = {i_data[WIDTH-2:0], i_serial_in};
      default:         o_next = i_data;
    endcase
  end

  // First pattern of a run; an all-zero LFSR seed would lock up, so use 1.
  always_comb begin
    o_first = i_seed;
    case (bist_mode_e'(i_mode))
      BIST_MODE_LFSR:  o_first = (i_seed == '0) ? WIDTH'(1) : i_seed;
      BIST_MODE_CNT:   o_first = i_seed;
      BIST_MODE_WALK:  o_first = WIDTH'(1);
      BIST_MODE_CHK:   o_first = w_chk;
      BIST_MODE_SHIFT: o_first = i_seed;
      default:         o_first = i_seed;
    endcase
  end

endmodule

// File: rtl/bist_pattern_gen.sv
// BIST stimulus source: on start, issues a programmed number of patterns
// over a valid/ready handshake and pulses done after the last accept.
// All outputs come straight from registers.
module bist_pattern_gen
  import bist_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               CNT_W = 16,
  parameter logic [WIDTH-1:0] POLY  = 8'hB8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [BIST_MODE_W-1:0] i_mode,
  input  logic [CNT_W-1:0]       i_num_patterns,
  input  logic [WIDTH-1:0]       i_seed,
  input  logic                   i_serial_in,
  input  logic                   i_pattern_ready,
  output logic                   o_pattern_valid,
  output logic [WIDTH-1:0]       o_data_out,
  output logic [CNT_W-1:0]       o_pattern_idx,
  output logic                   o_busy,
  output logic                   o_done
);

  bist_state_e      r_state;
  bist_state_e      w_state_next;
  bist_mode_e       r_mode;
  logic [CNT_W-1:0] r_num;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_idx;
  logic             r_done;

  logic             w_idle;
  logic             w_start_ok;
  logic             w_start_empty;
  logic             w_accept;
  logic             w_last;
  logic [BIST_MODE_W-1:0] w_pg_mode;
  logic [WIDTH-1:0] w_first;
  logic [WIDTH-1:0] w_next;

  assign w_idle = (r_state == BIST_ST_IDLE);

  // A start with a reserved mode is dropped entirely; an empty run only
  // produces the done pulse.
  assign w_start_ok    = w_idle && i_start && bist_mode_valid(i_mode) && (i_num_patterns != '0);
  assign w_start_empty = w_idle && i_start && bist_mode_valid(i_mode) && (i_num_patterns == '0);

  // Valid is asserted throughout RUN, so accept reduces to RUN && ready.
  assign w_accept = (r_state == BIST_ST_RUN) && i_pattern_ready;
  assign w_last   = (r_idx == (r_num - CNT_W'(1)));

  // In IDLE the pattern function sees the incoming mode so the first
  // pattern can be loaded on the start edge; in RUN it sees the latched one.
  assign w_pg_mode = w_idle ? i_mode : r_mode;

  bist_pattern_next #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_next (
    .i_mode      (w_pg_mode),
    .i_data      (r_data),
    .i_seed      (i_seed),
    .i_serial_in (i_serial_in),
    .o_next      (w_next),
    .o_first     (w_first)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= BIST_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: enter RUN on a usable start, leave on the last accept.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BIST_ST_IDLE: if (w_start_ok)          w_state_next = BIST_ST_RUN;
      BIST_ST_RUN:  if (w_accept && w_last)  w_state_next = BIST_ST_IDLE;
      default:                               w_state_next = BIST_ST_IDLE;
    endcase
  end

  // Output decode: everything is a register or a decode of the state register.
  always_comb begin
    o_busy          = (r_state == BIST_ST_RUN);
    o_pattern_valid = (r_state == BIST_ST_RUN);
    o_data_out      = r_data;
    o_pattern_idx   = r_idx;
    o_done          = r_done;
  end

  // Run parameters, pattern data, index and the done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode <= BIST_MODE_LFSR;
      r_num  <= '0;
      r_data <= '0;
      r_idx  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_start_empty || (w_accept && w_last);
      if (w_start_ok) begin
        r_mode <= bist_mode_e'(i_mode);
        r_num  <= i_num_patterns;
        r_data <= w_first;
        r_idx  <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          // Run complete: data_out keeps the final pattern.
          r_idx <= '0;
        end else begin
          r_idx  <= r_idx + CNT_W'(1);
          r_data <= w_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Directed self-checking bench for bist_pattern_gen (WIDTH=8, CNT_W=16).
module tb_bist_pattern_gen;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [2:0]  i_mode;
  logic [15:0] i_num_patterns;
  logic [7:0]  i_seed;
  logic        i_serial_in;
  logic        i_pattern_ready;
  logic        o_pattern_valid;
  logic [7:0]  o_data_out;
  logic [15:0] o_pattern_idx;
  logic        o_busy;
  logic        o_done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  bit         ser_q[$];
  int         stall_q[$];

  bist_pattern_gen #(
    .WIDTH (8),
    .CNT_W (16),
    .POLY  (8'hB8)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_start         (i_start),
    .i_mode          (i_mode),
    .i_num_patterns  (i_num_patterns),
    .i_seed          (i_seed),
    .i_serial_in     (i_serial_in),
    .i_pattern_ready (i_pattern_ready),
    .o_pattern_valid (o_pattern_valid),
    .o_data_out      (o_data_out),
    .o_pattern_idx   (o_pattern_idx),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic done_exp);
    chk({tag, " valid"}, 32'(o_pattern_valid), 32'd0);
    chk({tag, " busy"},  32'(o_busy),          32'd0);
    chk({tag, " done"},  32'(o_done),          32'(done_exp));
  endtask

  task automatic start_run(input logic [2:0] m, input logic [15:0] n, input logic [7:0] s);
    i_mode         = m;
    i_num_patterns = n;
    i_seed         = s;
    i_start        = 1'b1;
    step();
    i_start        = 1'b0;
  endtask

  // Walks a run that has just started, checking each pattern against exp_q.
  // stall_q[i] cycles of ready-low precede the accept of pattern i; ser_q[i]
  // is the serial bit presented at that accept. poke re-issues start mid-run.
  task automatic check_run(input string tag, input bit poke);
    int n;
    int stalls;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s data[%0d]", tag, i), 32'(o_data_out), 32'(exp_q[i]));
      chk($sformatf("%s idx[%0d]", tag, i), 32'(o_pattern_idx), 32'(i));
      chk($sformatf("%s valid[%0d]", tag, i), 32'(o_pattern_valid), 32'd1);
      chk($sformatf("%s busy[%0d]", tag, i), 32'(o_busy), 32'd1);
      chk($sformatf("%s done[%0d]", tag, i), 32'(o_done), 32'd0);
      stalls = (i < stall_q.size()) ? stall_q[i] : 0;
      for (int s = 0; s < stalls; s++) begin
        i_pattern_ready = 1'b0;
        step();
        chk($sformatf("%s stall data[%0d]", tag, i), 32'(o_data_out), 32'(exp_q[i]));
        chk($sformatf("%s stall idx[%0d]", tag, i), 32'(o_pattern_idx), 32'(i));
        chk($sformatf("%s stall valid[%0d]", tag, i), 32'(o_pattern_valid), 32'd1);
      end
      i_pattern_ready = 1'b1;
      i_serial_in = (i < ser_q.size()) ? ser_q[i] : 1'b0;
      if (poke && i == 1) begin
        i_start        = 1'b1;
        i_mode         = 3'd1;
        i_num_patterns = 16'd2;
        i_seed         = 8'h33;
      end
      step();
      i_start = 1'b0;
    end
    chk({tag, " end done"},  32'(o_done),          32'd1);
    chk({tag, " end valid"}, 32'(o_pattern_valid), 32'd0);
    chk({tag, " end busy"},  32'(o_busy),          32'd0);
    chk({tag, " end idx"},   32'(o_pattern_idx),   32'd0);
    chk({tag, " end data"},  32'(o_data_out),      32'(exp_q[n-1]));
    $display("run %s: %0d patterns checked", tag, n);
  endtask

  initial begin
    i_rst           = 1'b1;
    i_start         = 1'b0;
    i_mode          = 3'd0;
    i_num_patterns  = 16'd0;
    i_seed          = 8'h00;
    i_serial_in     = 1'b0;
    i_pattern_ready = 1'b1;

    // Reset state.
    step();
    step();
    chk_idle("reset", 1'b0);
    chk("reset data", 32'(o_data_out), 32'd0);
    chk("reset idx", 32'(o_pattern_idx), 32'd0);
    i_rst = 1'b0;
    step();
    chk_idle("post reset", 1'b0);

    // LFSR seed 0x01, then back-to-back (start in the done cycle) with seed 0.
    exp_q = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    start_run(3'd0, 16'd6, 8'h01);
    check_run("lfsr1", 1'b0);
    start_run(3'd0, 16'd6, 8'h00);
    check_run("lfsr0", 1'b0);

    // Walking one with wraparound.
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    start_run(3'd2, 16'd10, 8'hA5);
    check_run("walk", 1'b0);

    // Counter wrapping through zero.
    exp_q = '{8'hFE, 8'hFF, 8'h00};
    start_run(3'd1, 16'd3, 8'hFE);
    check_run("cnt", 1'b0);
    step();
    chk_idle("cnt after", 1'b0);

    // Checkerboard with ready low for two cycles on the second pattern.
    exp_q   = '{8'h55, 8'hAA, 8'h55, 8'hAA};
    stall_q = '{0, 2, 0, 0};
    start_run(3'd3, 16'd4, 8'h00);
    check_run("chk", 1'b0);
    stall_q.delete();
    step();

    // Shift mode: serial bits 1,0,0,0,0,0,0,1 on successive accepts.
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h81};
    ser_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    start_run(3'd4, 16'd9, 8'h00);
    check_run("shift", 1'b0);
    ser_q.delete();
    step();

    // Empty run: done only, no valid.
    start_run(3'd0, 16'd0, 8'h01);
    chk_idle("empty", 1'b1);
    step();
    chk_idle("empty after", 1'b0);

    // Reserved mode: nothing happens.
    start_run(3'd6, 16'd5, 8'h01);
    chk_idle("mode6", 1'b0);
    step();
    chk_idle("mode6 after", 1'b0);

    // Start re-issued during RUN is ignored.
    exp_q = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
    start_run(3'd0, 16'd4, 8'h01);
    check_run("start_in_run", 1'b1);
    step();
    chk_idle("start_in_run after", 1'b0);

    // Reset mid-run after three of eight LFSR patterns.
    start_run(3'd0, 16'd8, 8'h01);
    chk("rst run data0", 32'(o_data_out), 32'h01);
    step();
    chk("rst run data1", 32'(o_data_out), 32'hB8);
    step();
    chk("rst run data2", 32'(o_data_out), 32'h5C);
    #3;
    i_rst = 1'b1;
    #1;
    chk_idle("async rst", 1'b0);
    chk("async rst data", 32'(o_data_out), 32'd0);
    chk("async rst idx", 32'(o_pattern_idx), 32'd0);
    step();
    i_rst = 1'b0;
    step();
    chk_idle("rst after1", 1'b0);
    step();
    chk_idle("rst after2", 1'b0);

    // Fresh run replays from the seed.
    exp_q = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8};
    start_run(3'd0, 16'd8, 8'h01);
    check_run("lfsr8", 1'b0);
    step();
    chk_idle("final", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_pattern_gen.md
# bist_pattern_gen

Parametrised BIST stimulus source, successor to the fixed 8-bit serial data generator. On a `start` request it emits a programmed number of WIDTH-bit test patterns in one of five modes: LFSR, counter, walking-one, checkerboard or serial shift-in. Patterns leave over a valid/ready handshake, so the block feeds the BIST memory/DUT write path and tolerates downstream stalls. A one-cycle `done` pulse marks the end of a run for the BIST controller.

## Interface
- `WIDTH`, 8: pattern width, must be ≥ 2.
- `CNT_W`, 16: width of the pattern counter and `num_patterns`.
- `POLY`, 8'hB8: Galois LFSR tap mask, WIDTH bits. The default is maximal-length for WIDTH=8.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: run request, sampled in IDLE only.
- `mode` in 3: pattern mode, latched at start. Values: 0 LFSR, 1 counter, 2 walking-one, 3 checkerboard, 4 shift; 5–7 are reserved.
- `num_patterns` in CNT_W: patterns per run, latched at start.
- `seed` in WIDTH: first pattern for LFSR, counter and shift modes, latched at start.
- `serial_in` in 1: bit shifted in per accepted pattern in shift mode.
- `pattern_ready` in 1: downstream accepts the current pattern.
- `pattern_valid` out 1: `data_out` holds a valid pattern.
- `data_out` out WIDTH: current pattern.
- `pattern_idx` out CNT_W: index of the current pattern, 0-based.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse after the last pattern is accepted.

## Operation
- States:
  - IDLE: `busy=0`, `pattern_valid=0`.
  - RUN: `busy=1`, `pattern_valid=1`.
- Reset, asynchronous: state goes to IDLE and every output goes to 0. Internal latched mode, count and data also clear to 0.
- IDLE with `start=1`:
  - `mode` reserved (5–7): start is ignored and the block stays IDLE.
  - `num_patterns==0`: stay IDLE; `done` pulses next cycle; no pattern is issued.
  - Otherwise: latch `mode`, `num_patterns` and `seed`, go to RUN, set `pattern_idx=0` and load the first pattern.
- First pattern per mode:
  - LFSR: `seed`, or 1 if `seed==0` (avoids lockup).
  - Counter: `seed`.
  - Walking-one: 1.
  - Checkerboard: alternating bits with bit0=1 (0x55 at WIDTH=8).
  - Shift: `seed`.
- Accept means `pattern_valid && pattern_ready`. On accept:
  - If `pattern_idx == num_patterns-1`: go to IDLE, pulse `done`, clear `pattern_idx` to 0. `data_out` holds its last value.
  - Else: increment `pattern_idx` and advance `data_out`.
- Advance rules, all mod 2^WIDTH:
  - LFSR: `d = (d>>1) ^ (d[0] ? POLY : 0)`.
  - Counter: `d+1`, wrapping to 0.
  - Walking-one: rotate left, MSB wraps to bit0.
  - Checkerboard: bitwise invert.
  - Shift: `{d[WIDTH-2:0], serial_in}`, with `serial_in` sampled at the accept edge.
- `start` in RUN is ignored. Input changes in RUN have no effect, except `serial_in` in shift mode and `pattern_ready`.
- Stall: while `pattern_valid && !pattern_ready`, `data_out` and `pattern_idx` hold.

## Timing
- `start` sampled at edge t: `pattern_valid=1` with the first pattern from t+1. There is no combinational path from `start` to the outputs.
- With `pattern_ready` held high, N patterns appear on cycles t+1..t+N, one per cycle. At t+N+1: `done=1`, `busy=0`, `pattern_valid=0`.
- `done` is high for exactly one cycle. A `start` sampled in that same cycle is accepted, so back-to-back runs have a one-cycle gap.
- All outputs are registered. `pattern_ready` affects only next-state logic, never the current cycle's outputs.
- Reset asserted mid-run: the run is aborted immediately with no `done` pulse.
- `pattern_idx` width is CNT_W. `num_patterns = 2^CNT_W-1` is the maximum run length.

## Structure
- Package `bist_pkg` holds:
  - mode encodings `BIST_MODE_LFSR`, `BIST_MODE_CNT`, `BIST_MODE_WALK`, `BIST_MODE_CHK`, `BIST_MODE_SHIFT`;
  - the state encoding (IDLE, RUN).
- Sub-module `bist_pattern_next`: purely combinational next-pattern and first-pattern function.
  - Inputs: mode, current data, seed, `serial_in`.
  - Parameters: WIDTH, POLY.
  - The top level contains only the FSM, counter and registers.

## Test plan
- LFSR, WIDTH=8, seed 0x01, N=6, ready high: `data_out` = 0x01, 0xB8, 0x5C, 0x2E, 0x17, 0xB3; `done` at t+7. Seed 0x00 gives the same sequence.
- Walking-one, N=10, ready high: 0x01, 0x02, …, 0x80, 0x01, 0x02; `pattern_idx` 0..9. Counter, seed 0xFE, N=3: 0xFE, 0xFF, 0x00.
- Checkerboard, N=4, ready low on cycles 2–3: 0x55, 0xAA (held three cycles), 0x55, 0xAA; `pattern_idx` holds during the stall; `done` follows the last accept.
- Shift, seed 0x00, `serial_in` = 1, 0, 0, 0, 0, 0, 0, 1 on successive accepts, N=9: `data_out` progresses to 0x81 on the final pattern.
- Edge cases:
  - `num_patterns=0`: no valid, `done` one cycle after start.
  - Mode 6: nothing happens, `busy` stays 0.
  - `start` pulsed during RUN: ignored.
- Reset asserted after 3 of 8 LFSR patterns: all outputs 0 asynchronously, no `done`. A fresh start afterwards replays from the seed.
